// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule block.
// Contents: word width, small-sigma rotate/shift amounts, FSM state
// encoding, default schedule length and a rotate-right helper.
package sha256_pkg;

    localparam int WORD_W         = 32;
    localparam int ROUNDS_DEFAULT = 64;

    // s0(x) = rotr7 ^ rotr18 ^ shr3
    localparam int S0_ROT_A = 7;
    localparam int S0_ROT_B = 18;
    localparam int S0_SHR   = 3;

    // s1(x) = rotr17 ^ rotr19 ^ shr10
    localparam int S1_ROT_A = 17;
    localparam int S1_ROT_B = 19;
    localparam int S1_SHR   = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned       n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/msg_schedule_if.sv
// Handshake bundle between the message loader, the schedule expander and
// the round engine.
//   load_valid/load_data/load_ready : message word input (16 words per block)
//   w_valid/w_data/w_index/w_ready  : schedule word output stream
//   busy/done                        : block status
// slave  : view of the expander (msg_schedule)
// master : view of the surrounding logic (loader + round engine)
interface msg_schedule_if;
    import sha256_pkg::*;

    logic              load_valid;
    logic [WORD_W-1:0] load_data;
    logic              load_ready;
    logic              w_valid;
    logic [WORD_W-1:0] w_data;
    logic [5:0]        w_index;
    logic              w_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  load_valid, load_data, w_ready,
        output load_ready, w_valid, w_data, w_index, busy, done
    );

    modport master (
        output load_valid, load_data, w_ready,
        input  load_ready, w_valid, w_data, w_index, busy, done
    );

endinterface

// File: rtl/msg_sched_sigma.sv
// SHA-256 small-sigma function, purely combinational.
//   SEL = 0 : s0(x) = rotr7  ^ rotr18 ^ shr3
//   SEL = 1 : s1(x) = rotr17 ^ rotr19 ^ shr10
// Ports:
//   i_x : input word
//   o_y : sigma(i_x)
module msg_sched_sigma
    import sha256_pkg::*;
#(
    parameter int unsigned SEL = 0
) (
    input  logic [WORD_W-1:0] i_x,
    output logic [WORD_W-1:0] o_y
);

    localparam int unsigned ROT_A = (SEL == 0) ? S0_ROT_A : S1_ROT_A;
    localparam int unsigned ROT_B = (SEL == 0) ? S0_ROT_B : S1_ROT_B;
    localparam int unsigned SHR   = (SEL == 0) ? S0_SHR   : S1_SHR;

    assign o_y = rotr(i_x, ROT_A) ^ rotr(i_x, ROT_B) ^ (i_x >> SHR);

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message-schedule expander.
// Takes a block as 16 big-endian words W[0..15] and streams W[0..ROUNDS-1],
// one word per handshake, to the compression-round stage.
// Ports:
//   clk   : system clock, all state on rising edge
//   rst   : synchronous, active-high reset
//   sched : msg_schedule_if.slave (load stream in, schedule stream out,
//           busy/done status)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for W[0]; load_ready=1
// ST_LOAD   | collecting W[1..15] into the window, lc = next slot
// ST_EXPAND | presenting win[0] as W[t]; each handshake shifts the window
//           | and appends the next expanded word
module msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    msg_schedule_if.slave  sched
);

    state_t            r_state;
    logic [3:0]        r_lc;
    logic [5:0]        r_t;
    logic [WORD_W-1:0] r_win [16];
    logic              r_load_ready;
    logic              r_w_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_load_hs;
    logic              w_out_hs;
    logic              w_last;
    logic [WORD_W-1:0] w_s0;
    logic [WORD_W-1:0] w_s1;
    logic [WORD_W-1:0] w_new;

    // load_ready is low in EXPAND, so load_valid is ignored there.
    assign w_load_hs = sched.load_valid & r_load_ready;
    assign w_out_hs  = r_w_valid & sched.w_ready;
    assign w_last    = (r_t == 6'(ROUNDS - 1));

    msg_sched_sigma #(.SEL(0)) u_sigma0 (.i_x(r_win[1]),  .o_y(w_s0));
    msg_sched_sigma #(.SEL(1)) u_sigma1 (.i_x(r_win[14]), .o_y(w_s1));

    assign w_new = w_s1 + r_win[9] + w_s0 + r_win[0];

    // Window has no reset: its contents only matter after a full load.
    // lc is 0 in IDLE (reset value, and it wraps 15 -> 0 on the last load),
    // so win[lc] covers the first word too.
    always_ff @(posedge clk) begin
        if (w_load_hs) begin
            r_win[r_lc] <= sched.load_data;
        end else if (w_out_hs) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lc         <= 4'd0;
            r_t          <= 6'd0;
            r_load_ready <= 1'b1;
            r_w_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load_hs) begin
                        r_lc    <= 4'd1;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_load_hs) begin
                        r_lc <= r_lc + 4'd1;
                        if (r_lc == 4'd15) begin
                            r_t          <= 6'd0;
                            r_load_ready <= 1'b0;
                            r_w_valid    <= 1'b1;
                            r_state      <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    if (w_out_hs) begin
                        if (w_last) begin
                            r_t          <= 6'd0;
                            r_w_valid    <= 1'b0;
                            r_load_ready <= 1'b1;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_t <= r_t + 6'd1;
                        end
                    end
                end
                default: begin
                    r_lc         <= 4'd0;
                    r_t          <= 6'd0;
                    r_load_ready <= 1'b1;
                    r_w_valid    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign sched.load_ready = r_load_ready;
    assign sched.w_valid    = r_w_valid;
    assign sched.w_data     = r_win[0];
    assign sched.w_index    = r_t;
    assign sched.busy       = r_busy;
    assign sched.done       = r_done;

endmodule

// File: tb/tb_msg_schedule.sv
module tb_msg_schedule;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    msg_schedule_if ifc ();
    msg_schedule_if ifc16 ();

    msg_schedule #(.ROUNDS(64)) dut   (.clk(clk), .rst(rst), .sched(ifc));
    msg_schedule #(.ROUNDS(16)) dut16 (.clk(clk), .rst(rst), .sched(ifc16));

    int n_chk  = 0;
    int n_fail = 0;

    logic [37:0] sb [$];
    logic [31:0] blk [16];
    logic [31:0] got_w [64];

    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        d = d >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    // Push the reference schedule of blk onto the scoreboard.
    task automatic push_sched();
        logic [31:0] w [64];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[t];
            else        w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
            sb.push_back({6'(t), w[t]});
        end
    endtask

    task automatic load_block(input int gap_before, input int gap_len);
        push_sched();
        for (int i = 0; i < 16; i++) begin
            if (i == gap_before) begin
                for (int g = 0; g < gap_len; g++) begin
                    ifc.load_valid = 1'b0;
                    @(posedge clk); #1;
                    n_chk++;
                    if (ifc.w_valid !== 1'b0 || ifc.load_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL gap_hold: w_valid=%b load_ready=%b required 0/1", ifc.w_valid, ifc.load_ready);
                    end
                end
            end
            ifc.load_valid = 1'b1;
            ifc.load_data  = blk[i];
            n_chk++;
            if (ifc.load_ready !== 1'b1 || ifc.w_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_word%0d: load_ready=%b w_valid=%b required 1/0", i, ifc.load_ready, ifc.w_valid);
            end
            @(posedge clk); #1;
            n_chk++;
            if (ifc.done !== 1'b0 || ifc.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_status%0d: done=%b busy=%b required 0/1", i, ifc.done, ifc.busy);
            end
        end
        ifc.load_valid = 1'b0;
        n_chk++;
        if (ifc.w_valid !== 1'b1 || ifc.w_index !== 6'd0 || ifc.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wvalid_latency: w_valid=%b w_index=%0d load_ready=%b required 1/0/0", ifc.w_valid, ifc.w_index, ifc.load_ready);
        end
    endtask

    // Consume the stream; optional stall at word stall_t, reset at word rst_t,
    // and junk load_valid throughout EXPAND.
    task automatic drain(input int stall_t, input int stall_len, input int rst_t, input bit lv_junk);
        int got = 0;
        int stall_cnt = 0;
        bit fin = 1'b0;
        logic [37:0] e;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (lv_junk) begin
                ifc.load_valid = 1'b1;
                ifc.load_data  = 32'hDEADBEEF;
            end
            ifc.w_ready = 1'b1;
            n_chk++;
            if (ifc.w_valid !== 1'b1 || ifc.busy !== 1'b1 || ifc.done !== 1'b0 || ifc.load_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL expand_status t=%0d: w_valid=%b busy=%b done=%b load_ready=%b required 1/1/0/0",
                         got, ifc.w_valid, ifc.busy, ifc.done, ifc.load_ready);
            end
            if (got == rst_t) begin
                ifc.load_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                n_chk++;
                if (ifc.w_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.load_ready !== 1'b1 ||
                    ifc.done !== 1'b0 || ifc.w_index !== 6'd0) begin
                    n_fail++;
                    $display("FAIL mid_reset: w_valid=%b busy=%b load_ready=%b done=%b w_index=%0d required 0/0/1/0/0",
                             ifc.w_valid, ifc.busy, ifc.load_ready, ifc.done, ifc.w_index);
                end
                @(posedge clk); #1;
                n_chk++;
                if (ifc.done !== 1'b0 || ifc.w_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_reset_after: done=%b w_valid=%b required 0/0", ifc.done, ifc.w_valid);
                end
                sb.delete();
                fin = 1'b1;
            end else begin
                if (got == stall_t && stall_cnt < stall_len) begin
                    ifc.w_ready = 1'b0;
                    stall_cnt++;
                end
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: word %0d emitted with nothing expected", got);
                    fin = 1'b1;
                end else if (ifc.w_ready) begin
                    e = sb.pop_front();
                    n_chk++;
                    if ({ifc.w_index, ifc.w_data} !== e) begin
                        n_fail++;
                        $display("FAIL word t=%0d: got idx %0d data %h required idx %0d data %h",
                                 got, ifc.w_index, ifc.w_data, e[37:32], e[31:0]);
                    end
                    got_w[got] = ifc.w_data;
                    got++;
                end else begin
                    n_chk++;
                    if ({ifc.w_index, ifc.w_data} !== sb[0]) begin
                        n_fail++;
                        $display("FAIL stall_hold t=%0d: got idx %0d data %h required idx %0d data %h",
                                 got, ifc.w_index, ifc.w_data, sb[0][37:32], sb[0][31:0]);
                    end
                end
                if (!fin) begin
                    @(posedge clk); #1;
                    if (got == 64) begin
                        ifc.load_valid = 1'b0;
                        n_chk++;
                        if (ifc.done !== 1'b1 || ifc.w_valid !== 1'b0 || ifc.load_ready !== 1'b1 || ifc.busy !== 1'b0) begin
                            n_fail++;
                            $display("FAIL done_pulse: done=%b w_valid=%b load_ready=%b busy=%b required 1/0/1/0",
                                     ifc.done, ifc.w_valid, ifc.load_ready, ifc.busy);
                        end
                        fin = 1'b1;
                    end
                end
            end
        end
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words required 64", got);
        end
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        n_chk++;
        if (ifc.done !== 1'b0 || ifc.w_valid !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%b w_valid=%b busy=%b required 0/0/0", ifc.done, ifc.w_valid, ifc.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++;
        if (ifc.load_ready !== 1'b1 || ifc.w_valid !== 1'b0 || ifc.busy !== 1'b0 ||
            ifc.done !== 1'b0 || ifc.w_index !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: load_ready=%b w_valid=%b busy=%b done=%b w_index=%0d required 1/0/0/0/0",
                     ifc.load_ready, ifc.w_valid, ifc.busy, ifc.done, ifc.w_index);
        end
        n_chk++;
        if (ifc16.load_ready !== 1'b1 || ifc16.w_valid !== 1'b0 || ifc16.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state16: load_ready=%b w_valid=%b busy=%b required 1/0/0",
                     ifc16.load_ready, ifc16.w_valid, ifc16.busy);
        end
    endtask

    task automatic test_abc();
        logic [31:0] known [3];
        known[0] = 32'h61626380;
        known[1] = 32'h000F0000;
        known[2] = 32'h7DA86405;
        set_abc();
        load_block(-1, 0);
        drain(-1, 0, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (got_w[16+i] !== known[i]) begin
                n_fail++;
                $display("FAIL abc_W%0d: got %h required %h", 16 + i, got_w[16+i], known[i]);
            end
        end
        idle_step();
    endtask

    task automatic test_load_gaps();
        set_abc();
        load_block(8, 3);
        drain(-1, 0, -1, 1'b0);
        idle_step();
    endtask

    task automatic test_backpressure();
        set_abc();
        load_block(-1, 0);
        drain(20, 5, -1, 1'b0);
        idle_step();
    endtask

    task automatic test_reset_mid();
        set_abc();
        load_block(-1, 0);
        drain(-1, 0, 30, 1'b0);
        load_block(-1, 0);
        drain(-1, 0, -1, 1'b0);
        idle_step();
    endtask

    task automatic test_back_to_back();
        set_abc();
        load_block(-1, 0);
        drain(-1, 0, -1, 1'b1);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        load_block(-1, 0);
        drain(3, 2, -1, 1'b1);
        idle_step();
    endtask

    task automatic test_rounds16();
        int got = 0;
        bit fin = 1'b0;
        logic [37:0] q16 [$];
        logic [37:0] e;
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        ifc16.w_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ifc16.load_valid = 1'b1;
            ifc16.load_data  = blk[i];
            q16.push_back({6'(i), blk[i]});
            @(posedge clk); #1;
        end
        ifc16.load_valid = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            n_chk++;
            if (ifc16.w_valid !== 1'b1 || q16.size() == 0) begin
                n_fail++;
                $display("FAIL r16_valid: w_valid=%b pending=%0d required 1/nonzero", ifc16.w_valid, q16.size());
                fin = 1'b1;
            end else begin
                e = q16.pop_front();
                n_chk++;
                if ({ifc16.w_index, ifc16.w_data} !== e) begin
                    n_fail++;
                    $display("FAIL r16_word%0d: got idx %0d data %h required idx %0d data %h",
                             got, ifc16.w_index, ifc16.w_data, e[37:32], e[31:0]);
                end
                got++;
                @(posedge clk); #1;
                if (got == 16) begin
                    n_chk++;
                    if (ifc16.done !== 1'b1 || ifc16.w_valid !== 1'b0 || ifc16.busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL r16_done: done=%b w_valid=%b busy=%b required 1/0/0",
                                 ifc16.done, ifc16.w_valid, ifc16.busy);
                    end
                    fin = 1'b1;
                end
            end
        end
        if (!fin) begin
            n_chk++;
            n_fail++;
            $display("FAIL r16_timeout: got %0d words required 16", got);
        end
        @(posedge clk); #1;
        n_chk++;
        if (ifc16.done !== 1'b0 || ifc16.w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL r16_after: done=%b w_valid=%b required 0/0", ifc16.done, ifc16.w_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.load_valid   = 1'b0;
        ifc.load_data    = 32'h0;
        ifc.w_ready      = 1'b1;
        ifc16.load_valid = 1'b0;
        ifc16.load_data  = 32'h0;
        ifc16.w_ready    = 1'b1;
        test_reset();
        test_abc();
        test_load_gaps();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_rounds16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
